// File: rtl/img_eq_pkg.sv
// Shared widths and FSM state type for the image-equalisation CDF stage.
package img_eq_pkg;

  localparam int DATA_W        = 128;
  localparam int ADDR_W        = 16;
  localparam int BIN_W         = 32;
  localparam int BINS_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } cdf_state_t;

endpackage

// File: rtl/cdf_accum_if.sv
// Scratch-memory port bundle: one read port (1-cycle latency) and one write port.
interface cdf_accum_if;
  import img_eq_pkg::*;

  logic [ADDR_W-1:0] cdf_sc_mem_rd_addr;
  logic [DATA_W-1:0] cdf_sc_mem_rd_data;
  logic [ADDR_W-1:0] cdf_sc_mem_wt_addr;
  logic [DATA_W-1:0] cdf_sc_mem_wt_data;
  logic              cdf_sc_mem_wt_en;

  modport master (
    output cdf_sc_mem_rd_addr,
    input  cdf_sc_mem_rd_data,
    output cdf_sc_mem_wt_addr,
    output cdf_sc_mem_wt_data,
    output cdf_sc_mem_wt_en
  );

  modport slave (
    input  cdf_sc_mem_rd_addr,
    output cdf_sc_mem_rd_data,
    input  cdf_sc_mem_wt_addr,
    input  cdf_sc_mem_wt_data,
    input  cdf_sc_mem_wt_en
  );
endinterface

// File: rtl/cdf_prefix_add4.sv
// Combinational prefix chain: lane i of the output is carry-in plus bins 0..i
// of the input word. 32-bit lanes wrap modulo 2^32.
module cdf_prefix_add4
  import img_eq_pkg::*;
(
  input  logic [BIN_W-1:0]  i_sum,
  input  logic [DATA_W-1:0] i_word,
  output logic [DATA_W-1:0] o_prefix
);

  logic [BIN_W-1:0] w_acc;

  // Ripple the running sum across the lanes in ascending bin order.
  always_comb begin
    w_acc    = i_sum;
    o_prefix = '0;
    for (int unsigned i = 0; i < BINS_PER_WORD; i++) begin
      w_acc = w_acc + i_word[i*BIN_W +: BIN_W];
      o_prefix[i*BIN_W +: BIN_W] = w_acc;
    end
  end

endmodule

// File: rtl/cdf_accum.sv
// Histogram -> CDF accumulator. Reads one 4-bin histogram word per RD/WR pair,
// writes the running prefix sums back to the CDF region and latches the first
// nonzero CDF value as cdf_min.
module cdf_accum
  import img_eq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] HIST_BASE = 16'd0,
  parameter logic [ADDR_W-1:0] CDF_BASE  = 16'd64,
  parameter int unsigned       NUM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  cdf_accum_if.master       mem,
  output logic [BIN_W-1:0]  cdf_min,
  output logic              cdf_done,
  output logic              busy
);

  localparam int unsigned K_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  cdf_state_t        r_state;
  cdf_state_t        w_next;
  logic [K_W-1:0]    r_k;
  logic [BIN_W-1:0]  r_sum;
  logic              r_min_found;
  logic [BIN_W-1:0]  r_min;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wt_addr;
  logic [DATA_W-1:0] r_wt_data;
  logic [DATA_W-1:0] w_prefix;
  logic              w_last;
  logic              w_hit;
  logic [BIN_W-1:0]  w_first_nz;
  logic              w_wt_en;
  logic [ADDR_W-1:0] w_wt_addr;
  logic [DATA_W-1:0] w_wt_data;

  assign w_last = (r_k == K_W'(NUM_WORDS - 1));

  cdf_prefix_add4 u_prefix (
    .i_sum    (r_sum),
    .i_word   (mem.cdf_sc_mem_rd_data),
    .o_prefix (w_prefix)
  );

  // First nonzero lane of the current prefix word, lowest bin first.
  always_comb begin
    w_hit      = 1'b0;
    w_first_nz = '0;
    for (int unsigned i = 0; i < BINS_PER_WORD; i++) begin
      if (!w_hit && (w_prefix[i*BIN_W +: BIN_W] != '0)) begin
        w_hit      = 1'b1;
        w_first_nz = w_prefix[i*BIN_W +: BIN_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (enable) w_next = ST_RD;
      ST_RD:   w_next = ST_WR;
      ST_WR:   w_next = w_last ? ST_FIN : ST_RD;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; write address/data hold their last WR value elsewhere.
  always_comb begin
    w_wt_en   = 1'b0;
    cdf_done  = 1'b0;
    busy      = 1'b1;
    w_wt_addr = r_wt_addr;
    w_wt_data = r_wt_data;
    case (r_state)
      ST_IDLE: busy = 1'b0;
      ST_WR: begin
        w_wt_en   = 1'b1;
        w_wt_addr = CDF_BASE + ADDR_W'(r_k);
        w_wt_data = w_prefix;
      end
      ST_FIN:  cdf_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: the read address is loaded on the edge entering RD so it is
  // already stable for the whole RD cycle and the data arrives during WR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k         <= '0;
      r_sum       <= '0;
      r_min_found <= 1'b0;
      r_min       <= '0;
      r_rd_addr   <= '0;
      r_wt_addr   <= '0;
      r_wt_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_k         <= '0;
            r_sum       <= '0;
            r_min_found <= 1'b0;
            r_min       <= '0;
            r_rd_addr   <= HIST_BASE;
          end
        end
        ST_WR: begin
          r_sum     <= w_prefix[DATA_W-1 -: BIN_W];
          r_wt_addr <= w_wt_addr;
          r_wt_data <= w_prefix;
          if (!r_min_found && w_hit) begin
            r_min_found <= 1'b1;
            r_min       <= w_first_nz;
          end
          if (!w_last) begin
            r_k       <= r_k + 1'b1;
            r_rd_addr <= HIST_BASE + ADDR_W'(r_k) + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.cdf_sc_mem_rd_addr = r_rd_addr;
  assign mem.cdf_sc_mem_wt_addr = w_wt_addr;
  assign mem.cdf_sc_mem_wt_data = w_wt_data;
  assign mem.cdf_sc_mem_wt_en   = w_wt_en;
  assign cdf_min                = r_min;

endmodule

// File: tb/tb_cdf_accum.sv
// Scoreboard bench for cdf_accum: stimulus pushes expected writes/completions,
// a monitor pops and compares whenever the DUT writes or signals done.
module tb_cdf_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] cdf_min;
  logic        cdf_done;
  logic        busy;

  cdf_accum_if bus();

  cdf_accum #(
    .HIST_BASE (16'd0),
    .CDF_BASE  (16'd64),
    .NUM_WORDS (64)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mem      (bus),
    .cdf_min  (cdf_min),
    .cdf_done (cdf_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Histogram region of the scratch memory, one-cycle read latency.
  logic [127:0] hist [64];
  always @(posedge clk) bus.cdf_sc_mem_rd_data <= hist[bus.cdf_sc_mem_rd_addr[5:0]];

  typedef struct { logic [15:0] a; logic [127:0] d; int c; } wr_t;
  typedef struct { logic [31:0] m; int c; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Test histograms: 0 all ones, 1 only bin18=5, 2 all zero, 3 wrap case.
  function automatic logic [31:0] hist_bin(input int tid, input int b);
    case (tid)
      0:       return 32'd1;
      1:       return (b == 18) ? 32'd5 : 32'd0;
      3:       return (b == 0) ? 32'hFFFF_FFFF : ((b == 1) ? 32'd2 : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  // Hand-derived CDF values for the same tests.
  function automatic logic [31:0] exp_cdf(input int tid, input int b);
    case (tid)
      0:       return 32'(b + 1);
      1:       return (b < 18) ? 32'd0 : 32'd5;
      3:       return (b == 0) ? 32'hFFFF_FFFF : 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_min(input int tid);
    case (tid)
      0:       return 32'd1;
      1:       return 32'd5;
      3:       return 32'hFFFF_FFFF;
      default: return 32'd0;
    endcase
  endfunction

  task automatic load_hist(input int tid);
    for (int k = 0; k < 64; k++)
      for (int i = 0; i < 4; i++)
        hist[k][32*i +: 32] = hist_bin(tid, 4*k + i);
  endtask

  task automatic push_pass(input int tid, input int e0);
    wr_t w;
    dn_t d;
    for (int k = 0; k < 64; k++) begin
      w.a = 16'(64 + k);
      w.d = '0;
      for (int i = 0; i < 4; i++) w.d[32*i +: 32] = exp_cdf(tid, 4*k + i);
      w.c = e0 + 2*k + 1;
      wq.push_back(w);
    end
    d.m = exp_min(tid);
    d.c = e0 + 128;
    dq.push_back(d);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 128'(done_cnt), 128'(target));
  endtask

  task automatic run_pass(input int tid, input int pulse_at);
    int e0;
    int target;
    load_hist(tid);
    @(negedge clk);
    e0 = edge_cnt + 1;
    push_pass(tid, e0);
    target = done_cnt + 1;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    if (pulse_at > 0) begin
      while (edge_cnt - e0 < pulse_at - 1) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
    end
    wait_done(target);
    repeat (5) @(negedge clk);
    check("one_done", 128'(done_cnt), 128'(target));
    check("all_writes", 128'(wq.size()), 128'd0);
    check("min_hold", 128'(cdf_min), 128'(exp_min(tid)));
    check("idle_busy", 128'(busy), 128'd0);
    check("idle_wten", 128'(bus.cdf_sc_mem_wt_en), 128'd0);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    for (int k = 0; k < 64; k++) hist[k] = '0;
    fork
      begin : stim
        int e0;
        int d0;
        int target;
        repeat (3) @(negedge clk);
        check("rst_wten",  128'(bus.cdf_sc_mem_wt_en),   128'd0);
        check("rst_done",  128'(cdf_done),               128'd0);
        check("rst_busy",  128'(busy),                   128'd0);
        check("rst_min",   128'(cdf_min),                128'd0);
        check("rst_rdadr", 128'(bus.cdf_sc_mem_rd_addr), 128'd0);
        check("rst_wtadr", 128'(bus.cdf_sc_mem_wt_addr), 128'd0);
        check("rst_wtdat", bus.cdf_sc_mem_wt_data,       128'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_pass(0, 0);
        run_pass(1, 0);
        run_pass(2, 0);
        run_pass(3, 0);
        // Extra start request mid-pass must be ignored.
        run_pass(0, 50);

        // Reset in the middle of a pass aborts it.
        load_hist(0);
        @(negedge clk);
        e0 = edge_cnt + 1;
        push_pass(0, e0);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        while (edge_cnt - e0 < 59) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_wten", 128'(bus.cdf_sc_mem_wt_en), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_min",  128'(cdf_min), 128'd0);
        check("abort_done", 128'(cdf_done), 128'd0);
        wq.delete();
        dq.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (150) @(negedge clk);
        check("abort_nodone", 128'(done_cnt), 128'(d0));
        run_pass(0, 0);

        // Enable held high: second pass starts two edges after FIN.
        load_hist(0);
        @(negedge clk);
        e0 = edge_cnt + 1;
        push_pass(0, e0);
        push_pass(0, e0 + 130);
        target = done_cnt + 2;
        enable = 1'b1;
        while (edge_cnt < e0 + 131) @(negedge clk);
        enable = 1'b0;
        wait_done(target);
        repeat (5) @(negedge clk);
        check("b2b_dones",  128'(done_cnt), 128'(target));
        check("b2b_writes", 128'(wq.size()), 128'd0);
      end
      begin : mon
        wr_t w;
        dn_t d;
        forever begin
          @(negedge clk);
          if (bus.cdf_sc_mem_wt_en === 1'b1) begin
            if (wq.size() == 0) begin
              check("unexpected_write", 128'(bus.cdf_sc_mem_wt_addr), 128'hFFFF);
            end else begin
              w = wq.pop_front();
              check("wr_addr",  128'(bus.cdf_sc_mem_wt_addr), 128'(w.a));
              check("wr_data",  bus.cdf_sc_mem_wt_data,       w.d);
              check("wr_cycle", 128'(edge_cnt),               128'(w.c));
            end
          end
          if (cdf_done === 1'b1) begin
            done_cnt++;
            if (dq.size() == 0) begin
              check("unexpected_done", 128'(cdf_done), 128'd0);
            end else begin
              d = dq.pop_front();
              check("done_min",   128'(cdf_min),  128'(d.m));
              check("done_cycle", 128'(edge_cnt), 128'(d.c));
              check("done_busy",  128'(busy),     128'd1);
            end
          end
        end
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
